// File: rtl/acc_pkg.sv
// acc_pkg: shared types, constants and helpers for the accelerator offload
// blocks (offload controller, credit counter and future channel logic).
package acc_pkg;

  localparam int unsigned NumRs        = 3;
  localparam int unsigned InstrWidth   = 32;
  localparam int unsigned AccDataWidth = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RS = 2'd1,
    ISSUE   = 2'd2
  } offl_ctrl_state_e;

  typedef struct packed {
    logic [InstrWidth-1:0]                instr;
    logic [NumRs-1:0][AccDataWidth-1:0]   rs;
  } offl_req_t;

  // True when every operand named in use_rs is flagged available.
  function automatic logic operands_ready(input logic [NumRs-1:0] valid,
                                          input logic [NumRs-1:0] use_rs);
    return (valid & use_rs) == use_rs;
  endfunction

endpackage

// File: rtl/acc_credit_counter.sv
// acc_credit_counter: up/down credit counter saturating at MaxCount.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   inc_i, dec_i  : take / return one credit (both at once cancel out)
//   count_o       : current count
//   full_o        : count has reached MaxCount
//   underflow_o   : sticky; set by a return while the count is zero
module acc_credit_counter #(
  parameter  int unsigned MaxCount = 4,
  localparam int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            underflow_o
);

  logic [CntW-1:0] r_count;
  logic            r_underflow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (inc_i && !dec_i) begin
      if (r_count != CntW'(MaxCount)) r_count <= r_count + CntW'(1);
    end else if (dec_i && !inc_i) begin
      // An unmatched return leaves the count at zero and flags the error.
      if (r_count == '0) r_underflow <= 1'b1;
      else               r_count     <= r_count - CntW'(1);
    end
  end

  assign count_o     = r_count;
  assign full_o      = (r_count >= CntW'(MaxCount));
  assign underflow_o = r_underflow;

endmodule

// File: rtl/acc_offload_ctrl.sv
// acc_offload_ctrl: sequencer between the core offload port and the
// accelerator request/response channels.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   instr_valid_i/instr_rdata_i  : offload candidate from the core
//   instr_ready_o/instr_accept_o : consumed this cycle / 1=offloaded 0=rejected
//   pd_*                         : predecoder query (combinational)
//   rs_i, rs_valid_i             : operands rs1..rs3 (rs1 in LSBs) + availability
//   acc_req_*                    : request channel, valid/ready
//   acc_rsp_*                    : writeback response channel
//   wb_ready_i, wb_*_o           : writeback to core (pure pass-through)
//   outstanding_o                : writeback credits in use
//   err_o                        : sticky response-underflow error
// Optional feature macro: ACC_OFFL_CTRL_FASTPATH_EN (IDLE -> ISSUE directly
// when all needed operands are already valid).
module acc_offload_ctrl
  import acc_pkg::*;
#(
  parameter  int unsigned DataWidth      = 32,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       instr_valid_i,
  input  logic [InstrWidth-1:0]      instr_rdata_i,
  output logic                       instr_ready_o,
  output logic                       instr_accept_o,
  output logic [InstrWidth-1:0]      pd_instr_o,
  input  logic                       pd_accept_i,
  input  logic [1:0]                 pd_writeback_i,
  input  logic [NumRs-1:0]           pd_use_rs_i,
  input  logic [NumRs*DataWidth-1:0] rs_i,
  input  logic [NumRs-1:0]           rs_valid_i,
  output logic                       acc_req_valid_o,
  input  logic                       acc_req_ready_i,
  output logic [InstrWidth-1:0]      acc_req_instr_o,
  output logic [NumRs*DataWidth-1:0] acc_req_rs_o,
  input  logic                       acc_rsp_valid_i,
  output logic                       acc_rsp_ready_o,
  input  logic [DataWidth-1:0]       acc_rsp_data_i,
  input  logic [4:0]                 acc_rsp_rd_i,
  input  logic                       wb_ready_i,
  output logic                       wb_valid_o,
  output logic [DataWidth-1:0]       wb_data_o,
  output logic [4:0]                 wb_rd_o,
  output logic [CntW-1:0]            outstanding_o,
  output logic                       err_o
);

  offl_ctrl_state_e          r_state, w_state_nxt;
  logic [InstrWidth-1:0]     r_instr;
  logic [NumRs-1:0]          r_use_rs;
  logic [1:0]                r_wb;
  logic [NumRs*DataWidth-1:0] r_rs;

  logic             w_instr_ready, w_instr_accept, w_req_valid;
  logic             w_latch_instr, w_latch_rs, w_inc, w_full, w_rsp_hs;
  logic [NumRs-1:0] w_rs_use;

  // Unused operand slots are forced to zero so the accelerator sees clean data.
  function automatic logic [NumRs*DataWidth-1:0] mask_rs(
      input logic [NumRs*DataWidth-1:0] rs, input logic [NumRs-1:0] use_rs);
    logic [NumRs*DataWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NumRs; i++)
      if (use_rs[i]) m[i*DataWidth +: DataWidth] = rs[i*DataWidth +: DataWidth];
    return m;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_instr_ready  = 1'b0;
    w_instr_accept = 1'b0;
    w_req_valid    = 1'b0;
    w_latch_instr  = 1'b0;
    w_latch_rs     = 1'b0;
    w_rs_use       = r_use_rs;
    w_inc          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (instr_valid_i) begin
          if (!pd_accept_i) begin
            w_instr_ready = 1'b1;
          end else if (pd_writeback_i == 2'b00 || !w_full) begin
            // Credit check uses the registered count; a same-cycle response
            // only frees the credit on the following cycle.
            w_latch_instr = 1'b1;
            w_state_nxt   = WAIT_RS;
`ifdef ACC_OFFL_CTRL_FASTPATH_EN
            if (operands_ready(rs_valid_i, pd_use_rs_i)) begin
              w_latch_rs  = 1'b1;
              w_rs_use    = pd_use_rs_i;
              w_state_nxt = ISSUE;
            end
`endif
          end
        end
      end
      WAIT_RS: begin
        if (operands_ready(rs_valid_i, r_use_rs)) begin
          w_latch_rs  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_req_valid = 1'b1;
        if (acc_req_ready_i) begin
          w_instr_ready  = 1'b1;
          w_instr_accept = 1'b1;
          w_inc          = (r_wb != 2'b00);
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_instr  <= '0;
      r_use_rs <= '0;
      r_wb     <= '0;
      r_rs     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_instr) begin
        r_instr  <= instr_rdata_i;
        r_use_rs <= pd_use_rs_i;
        r_wb     <= pd_writeback_i;
      end
      if (w_latch_rs) r_rs <= mask_rs(rs_i, w_rs_use);
    end
  end

  assign w_rsp_hs = acc_rsp_valid_i & wb_ready_i;

  acc_credit_counter #(
    .MaxCount (MaxOutstanding)
  ) u_credit (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (w_inc),
    .dec_i       (w_rsp_hs),
    .count_o     (outstanding_o),
    .full_o      (w_full),
    .underflow_o (err_o)
  );

  // Handshake outputs are held low while reset is asserted.
  assign instr_ready_o   = w_instr_ready  & ~rst_i;
  assign instr_accept_o  = w_instr_accept & ~rst_i;
  assign acc_req_valid_o = w_req_valid    & ~rst_i;
  assign acc_req_instr_o = r_instr;
  assign acc_req_rs_o    = r_rs;
  assign pd_instr_o      = instr_rdata_i;

  assign acc_rsp_ready_o = wb_ready_i;
  assign wb_valid_o      = acc_rsp_valid_i;
  assign wb_data_o       = acc_rsp_data_i;
  assign wb_rd_o         = acc_rsp_rd_i;

endmodule

// File: tb/tb_acc_offload_ctrl.sv
// tb_acc_offload_ctrl: self-checking bench for acc_offload_ctrl.
// Table of single-instruction transactions, hand sequences for credit,
// simultaneous-event, underflow and reset corners, then randomized traffic
// checked against a transaction-level model of latency and credit count.
module tb_acc_offload_ctrl;

  localparam int DW   = 32;
  localparam int MAXO = 4;
`ifdef ACC_OFFL_CTRL_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_ready_o, instr_accept_o;
  logic [31:0] pd_instr_o;
  logic        pd_accept_i;
  logic [1:0]  pd_writeback_i;
  logic [2:0]  pd_use_rs_i;
  logic [95:0] rs_i;
  logic [2:0]  rs_valid_i;
  logic        acc_req_valid_o, acc_req_ready_i;
  logic [31:0] acc_req_instr_o;
  logic [95:0] acc_req_rs_o;
  logic        acc_rsp_valid_i, acc_rsp_ready_o;
  logic [31:0] acc_rsp_data_i;
  logic [4:0]  acc_rsp_rd_i;
  logic        wb_ready_i, wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  acc_offload_ctrl #(.DataWidth(DW), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i),
    .instr_ready_o(instr_ready_o), .instr_accept_o(instr_accept_o),
    .pd_instr_o(pd_instr_o), .pd_accept_i(pd_accept_i),
    .pd_writeback_i(pd_writeback_i), .pd_use_rs_i(pd_use_rs_i),
    .rs_i(rs_i), .rs_valid_i(rs_valid_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_instr_o(acc_req_instr_o), .acc_req_rs_o(acc_req_rs_o),
    .acc_rsp_valid_i(acc_rsp_valid_i), .acc_rsp_ready_o(acc_rsp_ready_o),
    .acc_rsp_data_i(acc_rsp_data_i), .acc_rsp_rd_i(acc_rsp_rd_i),
    .wb_ready_i(wb_ready_i), .wb_valid_o(wb_valid_o),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;   // model: writeback credits in use
  bit m_err   = 1'b0; // model: sticky underflow

  typedef struct {
    logic        acc;
    logic [31:0] instr;
    logic [2:0]  use_rs;
    logic [1:0]  wb;
    logic [95:0] rs;
    int          rs_dly;
    int          rdy_dly;
    logic [95:0] exp_rs;
  } vec_t;
  vec_t vecs[6];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] exp_mask(input logic [95:0] rs, input logic [2:0] u);
    logic [95:0] m;
    m = 96'd0;
    for (int s = 0; s < 3; s++)
      if (u[s]) m[s*32 +: 32] = rs[s*32 +: 32];
    return m;
  endfunction

  // mode 0: no response, 1: random (only while credits are in use), 2: forced
  task automatic set_rsp(input int mode, output logic dec);
    logic v, r;
    v = 1'b0;
    r = 1'($urandom);
    if (mode == 1) begin
      v = (m_cnt > 0) && ($urandom % 3 == 0);
      r = ($urandom % 4 != 0);
    end else if (mode == 2) begin
      v = 1'b1;
      r = 1'b1;
    end
    acc_rsp_valid_i = v;
    wb_ready_i      = r;
    acc_rsp_data_i  = $urandom;
    acc_rsp_rd_i    = 5'($urandom);
    dec = v & r;
  endtask

  task automatic chk_common();
    chkw("outstanding", {93'd0, outstanding_o}, 96'(m_cnt));
    chk1("err", err_o, m_err);
    chk1("wb_valid", wb_valid_o, acc_rsp_valid_i);
    chk1("rsp_ready", acc_rsp_ready_o, wb_ready_i);
    chkw("wb_data", {64'd0, wb_data_o}, {64'd0, acc_rsp_data_i});
  endtask

  task automatic clk_edge(input logic inc, input logic dec);
    @(posedge clk_i);
    if (rst_i) begin
      m_cnt = 0;
      m_err = 1'b0;
    end else if (inc && !dec) begin
      m_cnt++;
    end else if (dec && !inc) begin
      if (m_cnt == 0) m_err = 1'b1;
      else            m_cnt--;
    end
    #1;
  endtask

  task automatic idle(input int n, input int mode);
    logic dec;
    for (int i = 0; i < n; i++) begin
      instr_valid_i = 1'b0;
      set_rsp(mode, dec);
      #1;
      chk1("idle_ready", instr_ready_o, 1'b0);
      chk1("idle_reqv", acc_req_valid_o, 1'b0);
      chk_common();
      clk_edge(1'b0, dec);
    end
  endtask

  // One instruction from presentation to handshake. rsp_issue forces a
  // response handshake exactly on the issue cycle and none before it.
  task automatic run_txn(input logic acc, input logic [31:0] instr,
                         input logic [2:0] use_rs, input logic [1:0] wb,
                         input logic [95:0] rs, input int rs_dly, input int rdy_dly,
                         input logic [95:0] exp_rs, input logic rsp_issue, input int mode);
    logic dec, last;
    int   k_issue, guard;
    instr_valid_i   = 1'b1;
    instr_rdata_i   = instr;
    pd_accept_i     = acc;
    pd_writeback_i  = wb;
    pd_use_rs_i     = use_rs;
    acc_req_ready_i = 1'b0;
    if (!acc) begin
      rs_valid_i = 3'b111;
      rs_i       = rs;
      set_rsp(mode, dec);
      #1;
      chk1("rej_ready", instr_ready_o, 1'b1);
      chk1("rej_accept", instr_accept_o, 1'b0);
      chk1("rej_reqv", acc_req_valid_o, 1'b0);
      chkw("pd_instr", {64'd0, pd_instr_o}, {64'd0, instr});
      chk_common();
      clk_edge(1'b0, dec);
      instr_valid_i = 1'b0;
      return;
    end
    guard = 0;
    while (wb != 2'b00 && m_cnt >= MAXO) begin
      rs_valid_i = 3'($urandom);
      set_rsp(rsp_issue ? 0 : mode, dec);
      #1;
      chk1("stall_ready", instr_ready_o, 1'b0);
      chk1("stall_reqv", acc_req_valid_o, 1'b0);
      chk_common();
      clk_edge(1'b0, dec);
      guard++;
      if (guard > 200) begin
        n_tests++; n_fail++;
        $display("FAIL credit_timeout: stalled %0d cycles, want release", guard);
        instr_valid_i = 1'b0;
        return;
      end
    end
    k_issue = FAST ? rs_dly + 1 : ((rs_dly > 1 ? rs_dly : 1) + 1);
    for (int k = 0; k <= k_issue + rdy_dly; k++) begin
      rs_valid_i = (k >= rs_dly) ? (use_rs | 3'($urandom)) : (~use_rs & 3'($urandom));
      rs_i       = (k == k_issue - 1) ? rs : {$urandom, $urandom, $urandom};
      last       = (k == k_issue + rdy_dly);
      if (k < k_issue) acc_req_ready_i = 1'($urandom);
      else             acc_req_ready_i = last;
      if (rsp_issue) set_rsp(last ? 2 : 0, dec);
      else           set_rsp(mode, dec);
      #1;
      chk1("req_valid", acc_req_valid_o, k >= k_issue);
      chk1("instr_ready", instr_ready_o, last);
      if (last) chk1("instr_accept", instr_accept_o, 1'b1);
      if (k >= k_issue) begin
        chkw("req_rs", acc_req_rs_o, exp_rs);
        chkw("req_instr", {64'd0, acc_req_instr_o}, {64'd0, instr});
      end
      chk_common();
      clk_edge(last && wb != 2'b00, dec);
    end
    instr_valid_i   = 1'b0;
    acc_req_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        dec, r_acc;
    logic [2:0]  r_use;
    logic [1:0]  r_wb;
    logic [95:0] r_rs;
    int          r_d, r_rd, lat;

    vecs[0] = '{1'b0, 32'h0000_0013, 3'b000, 2'b00, 96'd0, 0, 0, 96'd0};
    vecs[1] = '{1'b1, 32'h0000_100B, 3'b011, 2'b00, {32'hFF, 32'h5A, 32'hA5}, 0, 0,
                {32'h0, 32'h5A, 32'hA5}};
    vecs[2] = '{1'b1, 32'h0000_200B, 3'b100, 2'b01, {32'h33, 32'h44, 32'h55}, 6, 0,
                {32'h33, 32'h0, 32'h0}};
    vecs[3] = '{1'b1, 32'h0000_300B, 3'b000, 2'b10, {32'h1, 32'h2, 32'h3}, 0, 2, 96'd0};
    vecs[4] = '{1'b1, 32'h0000_400B, 3'b111, 2'b11, {32'h1, 32'h2, 32'h3}, 1, 1,
                {32'h1, 32'h2, 32'h3}};
    vecs[5] = '{1'b1, 32'h0000_500B, 3'b101, 2'b00, {32'hDEAD, 32'hBEEF, 32'hCAFE}, 2, 0,
                {32'hDEAD, 32'h0, 32'hCAFE}};

    rst_i = 1'b1;
    instr_valid_i = 1'b0; instr_rdata_i = 32'd0; pd_accept_i = 1'b0;
    pd_writeback_i = 2'b00; pd_use_rs_i = 3'b000; rs_i = 96'd0; rs_valid_i = 3'b000;
    acc_req_ready_i = 1'b0; acc_rsp_valid_i = 1'b0; acc_rsp_data_i = 32'd0;
    acc_rsp_rd_i = 5'd0; wb_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk1("rst_ready", instr_ready_o, 1'b0);
    chk1("rst_accept", instr_accept_o, 1'b0);
    chk1("rst_reqv", acc_req_valid_o, 1'b0);
    chkw("rst_cnt", {93'd0, outstanding_o}, 96'd0);
    chk1("rst_err", err_o, 1'b0);
    chkw("rst_req_rs", acc_req_rs_o, 96'd0);
    chkw("rst_req_instr", {64'd0, acc_req_instr_o}, 96'd0);
    clk_edge(1'b0, 1'b0);

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].acc, vecs[v].instr, vecs[v].use_rs, vecs[v].wb, vecs[v].rs,
              vecs[v].rs_dly, vecs[v].rdy_dly, vecs[v].exp_rs, 1'b0, 0);
    chkw("table_cnt", {93'd0, outstanding_o}, 96'd3);
    idle(3, 2);

    // Credit exhaustion: four writeback instructions fill the credits.
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 32'h0000_600B + i, 3'b000, 2'b01, 96'd0, 0, 0, 96'd0, 1'b0, 0);
    chkw("credit_full", {93'd0, outstanding_o}, 96'd4);
    instr_valid_i = 1'b1; pd_accept_i = 1'b1; pd_writeback_i = 2'b01;
    pd_use_rs_i = 3'b000; instr_rdata_i = 32'h0000_700B; rs_valid_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      set_rsp(i == 3 ? 2 : 0, dec);
      #1;
      chk1("fifth_stall", instr_ready_o, 1'b0);
      chk1("fifth_reqv", acc_req_valid_o, 1'b0);
      chk_common();
      clk_edge(1'b0, dec);
    end
    chkw("credit_freed", {93'd0, outstanding_o}, 96'd3);
    run_txn(1'b1, 32'h0000_700B, 3'b000, 2'b01, 96'd0, 0, 0, 96'd0, 1'b0, 0);

    // Issue and response on the same edge at count 2.
    idle(2, 2);
    run_txn(1'b1, 32'h0000_800B, 3'b010, 2'b01, {32'h7, 32'h8, 32'h9}, 0, 1,
            {32'h0, 32'h8, 32'h0}, 1'b1, 0);
    chkw("simul_cnt", {93'd0, outstanding_o}, 96'd2);
    idle(2, 2);
    idle(1, 2);
    idle(3, 0);
    chk1("err_sticky", err_o, 1'b1);
    chkw("underflow_cnt", {93'd0, outstanding_o}, 96'd0);

    for (int t = 0; t < 40; t++) begin
      r_acc = ($urandom % 5) != 0;
      r_use = 3'($urandom);
      r_wb  = 2'($urandom);
      r_rs  = {$urandom, $urandom, $urandom};
      r_d   = (r_use == 3'b000) ? 0 : int'($urandom_range(0, 3));
      r_rd  = int'($urandom_range(0, 3));
      run_txn(r_acc, $urandom, r_use, r_wb, r_rs, r_d, r_rd, exp_mask(r_rs, r_use), 1'b0, 1);
    end
    idle(2, 1);

    // Reset while a request waits in ISSUE with ready low.
    lat = FAST ? 1 : 2;
    instr_valid_i = 1'b1; pd_accept_i = 1'b1; pd_writeback_i = 2'b00;
    pd_use_rs_i = 3'b000; instr_rdata_i = 32'h0000_900B; acc_req_ready_i = 1'b0;
    for (int i = 0; i < lat; i++) begin
      set_rsp(0, dec);
      #1;
      chk1("prerst_reqv", acc_req_valid_o, 1'b0);
      clk_edge(1'b0, dec);
    end
    #1;
    chk1("prerst_issue", acc_req_valid_o, 1'b1);
    rst_i = 1'b1;
    clk_edge(1'b0, 1'b0);
    rst_i = 1'b0;
    instr_valid_i = 1'b0;
    #1;
    chk1("midrst_reqv", acc_req_valid_o, 1'b0);
    chkw("midrst_cnt", {93'd0, outstanding_o}, 96'd0);
    chk1("midrst_err", err_o, 1'b0);
    clk_edge(1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_0013, 3'b000, 2'b00, 96'd0, 0, 0, 96'd0, 1'b0, 0);
    idle(2, 0);
    idle(1, 2);
    idle(2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_offload_ctrl.md
Name: acc_offload_ctrl

Overview:
- Sequencer between the core's offload port and the accelerator request/response channels.
- Queries the offload predecoder (acc_predecoder) combinationally and either rejects the instruction or collects its source operands.
- Issues accepted instructions to the accelerator with a valid/ready handshake.
- Tracks outstanding writeback responses with a credit counter.

Parameters:
- DataWidth, 32, width of each source operand and of writeback data.
- MaxOutstanding, 4, maximum in-flight instructions with writeback != 0; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_valid_i  in  1  core presents an offload candidate
- instr_rdata_i  in  32  instruction word
- instr_ready_o  out  1  instruction consumed this cycle
- instr_accept_o  out  1  qualifies instr_ready_o: 1 = offloaded, 0 = rejected
- pd_instr_o  out  32  instruction word to predecoder
- pd_accept_i  in  1  predecoder match
- pd_writeback_i  in  2  predecoder writeback field
- pd_use_rs_i  in  3  predecoder source-register use mask
- rs_i  in  3*DataWidth  operands rs1..rs3 (rs1 in LSBs)
- rs_valid_i  in  3  per-operand availability from the core scoreboard
- acc_req_valid_o  out  1  request valid
- acc_req_ready_i  in  1  accelerator accepts request
- acc_req_instr_o  out  32  latched instruction
- acc_req_rs_o  out  3*DataWidth  latched operands; unused slots are zero
- acc_rsp_valid_i  in  1  writeback response valid
- acc_rsp_ready_o  out  1  response ready (equals wb_ready_i)
- acc_rsp_data_i  in  DataWidth  response data
- acc_rsp_rd_i  in  5  destination register
- wb_valid_o  out  1  writeback to core (equals acc_rsp_valid_i)
- wb_data_o  out  DataWidth  pass-through of acc_rsp_data_i
- wb_rd_o  out  5  pass-through of acc_rsp_rd_i
- outstanding_o  out  $clog2(MaxOutstanding+1)  current credit count
- err_o  out  1  sticky protocol error

Behaviour:
- pd_instr_o = instr_rdata_i, always combinational.
- Core rule: the core holds instr_valid_i and instr_rdata_i stable until instr_ready_o is high.
- Reset (rst_i = 1 at a clock edge):
  - State goes to IDLE; counter, err_o and all latches clear.
  - All valid/ready outputs are 0, except acc_rsp_ready_o and wb_valid_o, which stay pure pass-throughs.
  - Reset mid-operation drops any pending request with no handshake. Responses arriving after reset that would underflow the counter set err_o.
- FSM state IDLE:
  - If instr_valid_i and !pd_accept_i: instr_ready_o = 1 and instr_accept_o = 0 in the same cycle; stay in IDLE.
  - If instr_valid_i and pd_accept_i and (pd_writeback_i == 0 or count < MaxOutstanding): latch instr, use_rs and writeback; go to WAIT_RS.
  - If the credit is unavailable: stall with instr_ready_o = 0.
- FSM state WAIT_RS:
  - When (rs_valid_i & use_rs) == use_rs, latch rs_i, masked by use_rs (unused slots become 0), and go to ISSUE.
  - If use_rs == 0, leave after one cycle.
- FSM state ISSUE:
  - acc_req_valid_o = 1; instr and operands are held stable.
  - On acc_req_ready_i: instr_ready_o = 1 and instr_accept_o = 1 in the same cycle. If writeback != 0, the count increments. Go to IDLE.
- Latency, IDLE accept to acc_req_valid_o: minimum 2 cycles.
- Counter:
  - Decrements on the acc_rsp_valid_i & acc_rsp_ready_o handshake.
  - Simultaneous increment and decrement leaves the count unchanged.
  - A response at count == 0 does not change the count and sets err_o, which holds until reset.
- The credit check uses the registered count. A response in the same cycle does not free the credit until the next cycle.

Optional Feature:
- Macro: ACC_OFFL_CTRL_FASTPATH_EN.
- When defined: in IDLE, an accepted instruction whose needed operands are all valid that cycle latches its operands directly and goes to ISSUE, skipping WAIT_RS. Minimum latency is 1 cycle.
- When undefined: always passes through WAIT_RS as described above.

Decomposition:
- Add to acc_pkg:
  - typedef offl_ctrl_state_e {IDLE, WAIT_RS, ISSUE}
  - typedef offl_req_t {instr, rs[3]}
  - localparam NumRs = 3
- Natural sub-module: acc_credit_counter, an up/down counter with max limit, underflow flag and simultaneous increment/decrement handling. It is reusable for other accelerator channels.

Test Plan:
- Reject: instr 0x00000013, pd_accept_i = 0 -> instr_ready_o = 1 and instr_accept_o = 0 in the same cycle; no acc_req_valid_o.
- Accept with two operands:
  - Stimulus: use_rs = 3'b011, rs1 = 0xA5, rs2 = 0x5A, rs3 = 0xFF, rs_valid_i = 3'b111, acc_req_ready_i = 1.
  - Required: acc_req_valid_o 2 cycles after accept (1 with FASTPATH); acc_req_rs_o = {0, 0x5A, 0xA5}; instr_accept_o = 1.
- Operand stall: use_rs = 3'b100, rs_valid_i[2] low for 5 cycles -> remains in WAIT_RS with acc_req_valid_o = 0; issues the cycle after rs_valid_i[2] rises.
- Credit exhaustion:
  - Stimulus: MaxOutstanding = 4; 5 back-to-back accepted instrs with writeback = 2'b01; no responses.
  - Required: outstanding_o = 4 and the 5th stalls with instr_ready_o = 0. One response handshake releases it the next cycle.
- Simultaneous events and underflow: response handshake in the same cycle as an issue at count = 2 -> count stays 2; a response at count = 0 -> err_o = 1 and stays 1.
- Reset mid-ISSUE with acc_req_ready_i = 0 -> the next cycle has acc_req_valid_o = 0, outstanding_o = 0, state IDLE.
